// File: rtl/io_defs.sv
// Shared definitions for the processor input-port transmitter: FSM state
// encodings, byte width and the starvation fill byte.
package io_defs;

    localparam int         IO_BYTE_W   = 8;
    localparam logic [7:0] IO_TMO_FILL = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_ACK   = 2'b10
    } io_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with occupancy count; a push on a pop cycle is accepted
// even when full, since the popped slot frees room on the same edge.
module byte_fifo
    import io_defs::*;
#(
    parameter int DEPTH   = 4,
    parameter int A_WIDTH = 2
) (
    input  logic                 g_clk,
    input  logic                 g_clr,
    input  logic                 push,
    input  logic [IO_BYTE_W-1:0] wr_data,
    input  logic                 pop,
    output logic [IO_BYTE_W-1:0] head,
    output logic [A_WIDTH:0]     count,
    output logic                 full
);

    logic [IO_BYTE_W-1:0] r_mem [DEPTH];
    logic [A_WIDTH-1:0]   r_wr_ptr;
    logic [A_WIDTH-1:0]   r_rd_ptr;
    logic [A_WIDTH:0]     r_count;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign w_pop_ok  = pop && (r_count != '0);
    assign w_push_ok = push && (!full || w_pop_ok);

    assign full  = (r_count == (A_WIDTH+1)'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge g_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (A_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (A_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_tx_port.sv
// Byte source feeding the processor input port via a four-phase handshake.
// Optional request-starvation timeout enabled by defining IO_TX_TIMEOUT_EN.
module io_tx_port
    import io_defs::*;
#(
    parameter int DEPTH      = 4,
    parameter int A_WIDTH    = 2,
    parameter int TMO_CYCLES = 255
) (
    input  logic                 g_clk,
    input  logic                 g_clr,
    input  logic [IO_BYTE_W-1:0] wr_data,
    input  logic                 wr_en,
    output logic                 full,
    output logic [A_WIDTH:0]     count,
    output logic                 overflow,
    input  logic                 hs_req,
    output logic                 hs_ack,
    output logic [IO_BYTE_W-1:0] bus_data,
    output logic                 tmo
);

    io_state_t            r_state;
    logic                 r_hs_ack;
    logic [IO_BYTE_W-1:0] r_bus_data;
    logic                 r_fill;
    logic                 r_overflow;
    logic [IO_BYTE_W-1:0] w_head;
    logic [A_WIDTH:0]     w_count;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_tmo_fire;

    // The fill byte never came from the FIFO, so completing it must not pop.
    assign w_pop = (r_state == ST_ACK) && !hs_req && !r_fill;

    byte_fifo #(
        .DEPTH   (DEPTH),
        .A_WIDTH (A_WIDTH)
    ) u_fifo (
        .g_clk   (g_clk),
        .g_clr   (g_clr),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (w_pop),
        .head    (w_head),
        .count   (w_count),
        .full    (w_full)
    );

    assign full     = w_full;
    assign count    = w_count;
    assign overflow = r_overflow;
    assign hs_ack   = r_hs_ack;
    assign bus_data = r_bus_data;

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_state    <= ST_IDLE;
            r_hs_ack   <= 1'b0;
            r_bus_data <= '0;
            r_fill     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hs_ack <= 1'b0;
                    if (hs_req && (w_count != '0)) begin
                        r_bus_data <= w_head;
                        r_fill     <= 1'b0;
                        r_state    <= ST_SETUP;
                    end else if (w_tmo_fire) begin
                        r_bus_data <= IO_TMO_FILL;
                        r_fill     <= 1'b1;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (hs_req) begin
                        r_hs_ack <= 1'b1;
                        r_state  <= ST_ACK;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    if (!hs_req) begin
                        r_hs_ack <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_hs_ack <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IO_TX_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo;
    logic          w_starve;

    assign w_starve   = (r_state == ST_IDLE) && hs_req && (w_count == '0);
    assign w_tmo_fire = w_starve && (r_tmo_cnt == TW'(TMO_CYCLES - 1));
    assign tmo        = r_tmo;

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else begin
            if (!w_starve) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != TW'(TMO_CYCLES)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_fire) begin
                r_tmo <= 1'b1;
            end
        end
    end
`else
    assign w_tmo_fire = 1'b0;
    assign tmo        = 1'b0;
`endif

endmodule

// File: tb/tb_io_tx_port.sv
// Scoreboard bench for io_tx_port: stimulus predicts delivered bytes into a
// queue, an independent monitor checks each byte as hs_ack rises.
module tb_io_tx_port;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       g_clk   = 1'b0;
    logic       g_clr   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       hs_req  = 1'b0;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       hs_ack;
    logic [7:0] bus_data;
    logic       tmo;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] ref_q[$];
    logic [7:0] exp_q[$];
    bit         m_ovf    = 1'b0;
    bit         mon_prev = 1'b0;

    io_tx_port #(
        .DEPTH      (DEPTH),
        .A_WIDTH    (2),
        .TMO_CYCLES (TMO)
    ) dut (
        .g_clk    (g_clk),
        .g_clr    (g_clr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .hs_req   (hs_req),
        .hs_ack   (hs_ack),
        .bus_data (bus_data),
        .tmo      (tmo)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: each rising hs_ack must present the next expected byte.
    always @(posedge g_clk) begin
        #1;
        if (g_clr && hs_ack && !mon_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL deliver_unexpected actual=%0h expected=none", bus_data);
            end else begin
                chk("deliver", {24'h0, bus_data}, {24'h0, exp_q.pop_front()});
            end
        end
        mon_prev = hs_ack;
    end

    // One clock: drive inputs, apply the FIFO rules to the reference queue, check occupancy.
    task automatic step(input logic we, input logic [7:0] wd, input logic req, input logic pop);
        int sz;
        @(negedge g_clk);
        wr_en   = we;
        wr_data = wd;
        hs_req  = req;
        @(posedge g_clk);
        sz = ref_q.size();
        if (pop && sz > 0) void'(ref_q.pop_front());
        if (we) begin
            if (sz < DEPTH || (pop && sz > 0)) begin
                ref_q.push_back(wd);
                exp_q.push_back(wd);
            end else begin
                m_ovf = 1'b1;
            end
        end
        #1;
        chk("count", {29'h0, count}, ref_q.size());
        chk("full", {31'h0, full}, {31'h0, (ref_q.size() == DEPTH)});
        chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    endtask

    // Processor-side handshake; the optional push lands on the release (pop) edge.
    task automatic handshake(input bit rnd, input logic pwe, input logic [7:0] pwd);
        int n;
        logic we;
        we = rnd && ($urandom_range(0, 1) == 1);
        step(we, 8'($urandom), 1'b1, 1'b0);
        n = 0;
        while (!hs_ack && n < 30) begin
            we = rnd && ($urandom_range(0, 1) == 1);
            step(we, 8'($urandom), 1'b1, 1'b0);
            n++;
        end
        if (!hs_ack) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=%0b expected=1", hs_ack);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end else begin
            if (rnd) begin
                we = ($urandom_range(0, 1) == 1);
                step(we, 8'($urandom), 1'b0, 1'b1);
            end else begin
                step(pwe, pwd, 1'b0, 1'b1);
            end
            chk("ack_release", {31'h0, hs_ack}, 0);
        end
    endtask

    task automatic reset_midcycle();
        #2;
        g_clr  = 1'b0;
        wr_en  = 1'b0;
        hs_req = 1'b0;
        #1;
        chk("rst_count", {29'h0, count}, 0);
        chk("rst_ack", {31'h0, hs_ack}, 0);
        chk("rst_bus", {24'h0, bus_data}, 32'h00);
        chk("rst_full", {31'h0, full}, 0);
        chk("rst_ovf", {31'h0, overflow}, 0);
        chk("rst_tmo", {31'h0, tmo}, 0);
        ref_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        @(negedge g_clk);
        @(negedge g_clk);
        g_clr = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge g_clk);
        g_clr = 1'b1;

        // Reset mid-handshake
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_reset_ack", {31'h0, hs_ack}, 1);
        reset_midcycle();

        // Basic transfer latency
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("basic_bus", {24'h0, bus_data}, 32'hA5);
        chk("basic_ack1", {31'h0, hs_ack}, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("basic_ack2", {31'h0, hs_ack}, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("basic_release", {31'h0, hs_ack}, 0);
        chk("basic_hold", {24'h0, bus_data}, 32'hA5);

        // Order and pointer wrap
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        handshake(1'b0, 1'b1, 8'h55);
        handshake(1'b0, 1'b1, 8'h66);
        for (int i = 0; i < 4; i++) handshake(1'b0, 1'b0, 8'h00);

        // Push on pop edge while full, then true overflow
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b0, 1'b0);
        step(1'b1, 8'hDD, 1'b0, 1'b0);
        handshake(1'b0, 1'b1, 8'h77);
        step(1'b1, 8'h88, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) handshake(1'b0, 1'b0, 8'h00);

        // Abort during setup, then starvation
        step(1'b1, 8'h5B, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("abort_bus", {24'h0, bus_data}, 32'h5B);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("abort_ack", {31'h0, hs_ack}, 0);
        handshake(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("starve_ack", {31'h0, hs_ack}, 0);
        end
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        handshake(1'b0, 1'b0, 8'h00);

        // Request with empty FIFO for the timeout window
`ifdef IO_TX_TIMEOUT_EN
        exp_q.push_back(8'hFF);
        for (int i = 0; i < TMO; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("tmo_bus", {24'h0, bus_data}, 32'hFF);
        chk("tmo_flag", {31'h0, tmo}, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("tmo_ack", {31'h0, hs_ack}, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("tmo_release", {31'h0, hs_ack}, 0);
        chk("tmo_sticky", {31'h0, tmo}, 1);
`else
        for (int i = 0; i < TMO + 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("notmo_ack", {31'h0, hs_ack}, 0);
        end
        chk("notmo_flag", {31'h0, tmo}, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
`endif

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 3);
            if (ref_q.size() == 0 || r == 0) begin
                step(($urandom_range(0, 1) == 1), 8'($urandom), 1'b0, 1'b0);
            end else if (r == 1) begin
                step(($urandom_range(0, 1) == 1), 8'($urandom), 1'b1, 1'b0);
                step(($urandom_range(0, 1) == 1), 8'($urandom), 1'b0, 1'b0);
            end else begin
                handshake(1'b1, 1'b0, 8'h00);
            end
        end
        while (ref_q.size() > 0) handshake(1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("exp_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
